// File: rtl/operate_sequencer.sv
// Multi-cycle sequencer for PDP-8 operate (group 1/2/3) microinstructions.
// Define MQ_EN to build the MQ register and group 3 execution; otherwise group 3 is a NOP.
module operate_sequencer #(
  parameter int WORD_W     = 12,
  parameter bit HLT_STICKY = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [11:0]       instr,
  input  logic [WORD_W-1:0] ac_in,
  input  logic              l_in,
  input  logic [WORD_W-1:0] pc_in,
  input  logic [WORD_W-1:0] sw_reg,
  input  logic              clear_halt,
  output logic [11:0]       dec_ireg,
  output logic [WORD_W-1:0] dec_ac,
  output logic              dec_l,
  input  logic [WORD_W-1:0] ac_micro,
  input  logic              l_micro,
  input  logic              skip,
  input  logic              micro_g1,
  input  logic              micro_g2,
  input  logic              micro_g3,
  output logic              busy,
  output logic              done,
  output logic [WORD_W-1:0] ac_out,
  output logic              l_out,
  output logic [WORD_W-1:0] pc_out,
  output logic              halt,
  output logic              illegal,
  output logic [WORD_W-1:0] mq_out
);

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, COMMIT} state_t;

  state_t            state;
  logic              ill_r;
  logic [WORD_W-1:0] pc_r;
  logic [WORD_W-1:0] acm_r;
  logic              lm_r, skip_r, g1_r, g2_r, g3_r;

  logic [WORD_W-1:0] ac_next, pc_next;
  logic              l_next, hlt_cmd;

`ifdef MQ_EN
  logic [WORD_W-1:0] mq_r, mq_next, t_val;
  assign mq_out = mq_r;
`else
  assign mq_out = '0;
`endif

  // Commit values are derived from the held decoder inputs, so skip/CLA/OSR see pre-instruction AC/L.
  always_comb begin
    ac_next = dec_ac;
    l_next  = dec_l;
    pc_next = pc_r + WORD_W'(1);
    hlt_cmd = 1'b0;
`ifdef MQ_EN
    mq_next = mq_r;
    t_val   = dec_ireg[7] ? '0 : dec_ac;
`endif
    if (!ill_r) begin
      if (g1_r) begin
        ac_next = acm_r;
        l_next  = lm_r;
      end else if (g2_r) begin
        ac_next = (dec_ireg[7] ? '0 : dec_ac) | (dec_ireg[2] ? sw_reg : '0);
        if (skip_r)
          pc_next = pc_r + WORD_W'(2);
        hlt_cmd = dec_ireg[1];
      end else if (g3_r) begin
`ifdef MQ_EN
        case ({dec_ireg[6], dec_ireg[4]})
          2'b11: begin ac_next = mq_r;         mq_next = t_val; end
          2'b10: begin ac_next = t_val | mq_r;                  end
          2'b01: begin ac_next = '0;           mq_next = t_val; end
          default: ac_next = t_val;
        endcase
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      ill_r    <= 1'b0;
      pc_r     <= '0;
      acm_r    <= '0;
      lm_r     <= 1'b0;
      skip_r   <= 1'b0;
      g1_r     <= 1'b0;
      g2_r     <= 1'b0;
      g3_r     <= 1'b0;
      dec_ireg <= '0;
      dec_ac   <= '0;
      dec_l    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      illegal  <= 1'b0;
      halt     <= 1'b0;
      ac_out   <= '0;
      l_out    <= 1'b0;
      pc_out   <= '0;
`ifdef MQ_EN
      mq_r     <= '0;
`endif
    end else begin
      done    <= 1'b0;
      illegal <= 1'b0;
      // A halting commit wins over a simultaneous clear_halt.
      if (state == COMMIT && hlt_cmd)
        halt <= 1'b1;
      else if (clear_halt || !HLT_STICKY)
        halt <= 1'b0;

      case (state)
        IDLE: begin
          if (start && !halt) begin
            dec_ireg <= instr;
            dec_ac   <= ac_in;
            dec_l    <= l_in;
            pc_r     <= pc_in;
            busy     <= 1'b1;
            if (instr[11:9] != 3'o7) begin
              ill_r <= 1'b1;
              state <= COMMIT;
            end else begin
              ill_r <= 1'b0;
              state <= ISSUE;
            end
          end
        end
        ISSUE: state <= CAPTURE;
        CAPTURE: begin
          acm_r  <= ac_micro;
          lm_r   <= l_micro;
          skip_r <= skip;
          g1_r   <= micro_g1;
          g2_r   <= micro_g2;
          g3_r   <= micro_g3;
          state  <= COMMIT;
        end
        COMMIT: begin
          ac_out  <= ac_next;
          l_out   <= l_next;
          pc_out  <= pc_next;
          done    <= 1'b1;
          illegal <= ill_r;
          busy    <= 1'b0;
`ifdef MQ_EN
          mq_r    <= mq_next;
`endif
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/operate_sequencer.md
OPERATE_SEQUENCER -- requirements
Module: operate_sequencer

Interface
REQ-001 Parameters SHALL be: WORD_W, 12, data/PC width (fixed, matches `word`); HLT_STICKY, 1, halt flag held until clear_halt (0 = single-cycle pulse).
REQ-002 Ports SHALL be:
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  execute request
- instr  in  12  instruction word
- ac_in  in  word  current AC
- l_in  in  1  current link
- pc_in  in  word  address of next sequential instruction
- sw_reg  in  word  front-panel switches
- clear_halt  in  1  clears halt
- dec_ireg  out  12  to decoder i_reg
- dec_ac  out  word  to decoder ac_reg
- dec_l  out  1  to decoder l_reg
- ac_micro  in  word  decoder AC result
- l_micro  in  1  decoder link result
- skip  in  1  decoder skip
- micro_g1, micro_g2, micro_g3  in  1 each  decoder group flags
- busy  out  1  operation in flight
- done  out  1  one-cycle completion pulse
- ac_out  out  word  committed AC
- l_out  out  1  committed link
- pc_out  out  word  committed PC
- halt  out  1  HLT executed
- illegal  out  1  one-cycle pulse, non-operate opcode
- mq_out  out  word  MQ register (MQ_EN only)

Function
REQ-003 FSM states SHALL be IDLE, ISSUE, CAPTURE, COMMIT, with one state per cycle and no other states.
REQ-004 In IDLE, when start=1 and halt=0, the block SHALL register instr/ac_in/l_in/pc_in and go to ISSUE; start SHALL be ignored in all other states and while halt=1.
REQ-005 In ISSUE, the registered values SHALL drive dec_ireg/dec_ac/dec_l; these outputs SHALL stay stable through CAPTURE.
REQ-006 In CAPTURE, the block SHALL sample ac_micro, l_micro, skip and the group flags.
REQ-007 In COMMIT, the block SHALL update ac_out/l_out/pc_out, pulse done, and return to IDLE. done SHALL assert exactly 3 cycles after the start-sampling edge.
REQ-008 busy SHALL be 1 in ISSUE, CAPTURE and COMMIT, and 0 in IDLE.
REQ-009 If instr[11:9] != 3'o7, the block SHALL go IDLE->COMMIT directly, pulse illegal and done together, leave AC/L unchanged, and set pc_out=pc+1.
REQ-010 Group 1 (micro_g1): AC/L SHALL come from ac_micro/l_micro; pc_out=pc+1.
REQ-011 Group 2 (micro_g2):
- skip SHALL be evaluated on the pre-instruction AC/L (decoder input).
- AC SHALL be (instr[7] ? 0 : ac), then OR'd with sw_reg if instr[2] (OSR).
- L SHALL be unchanged.
- pc_out SHALL be pc+2 if skip, else pc+1.
- instr[1] (HLT) SHALL set halt.
REQ-012 PC arithmetic SHALL be modulo 4096: 7777+1=0000; 7776+2=0000; 7777+2=0001.
REQ-013 Group 3 SHALL follow REQ-021/REQ-022.
REQ-014 With HLT_STICKY=1, halt SHALL clear only on clear_halt or reset. If clear_halt and an HLT commit occur in the same cycle, halt SHALL be 1.
REQ-015 With HLT_STICKY=0, halt SHALL be a one-cycle pulse coincident with done.

Reset
REQ-016 On rst_n=0, asynchronously: FSM=IDLE; busy, done, illegal, halt, l_out=0; ac_out, pc_out, mq_out=0000; dec_* = 0.
REQ-017 Reset mid-operation SHALL abort with no done pulse and no register update.
REQ-018 The first start SHALL be accepted on the first rising edge after rst_n deasserts.

Configuration
REQ-019 Macro MQ_EN SHALL compile in the MQ register and the group 3 execution.
REQ-020 Without MQ_EN: mq_out SHALL be tied to 0; group 3 SHALL be a NOP (AC/L unchanged, pc+1).
REQ-021 With MQ_EN, group 3 SHALL compute t = instr[7] ? 0 : AC, then:
- MQA & MQL (bits 6, 4): swap, AC=MQ, MQ=t.
- MQA only: AC = t | MQ.
- MQL only: MQ = t, AC = 0.
- neither: AC = t.
REQ-022 With MQ_EN, for group 3: L SHALL be unchanged, pc_out=pc+1, and mq_out SHALL update only in COMMIT.

Verification
REQ-023 7201 (CLA IAC), ac=1234, l=1, pc=0100 -> done at +3 cycles; ac=0001, l=1, pc=0101.
REQ-024 7440 (SZA), ac=0000, pc=0200 -> pc=0202; with ac=0001 -> pc=0201; ac unchanged.
REQ-025 7702 (SMA CLA HLT), ac=4000, pc=0300 -> pc=0302, ac=0000, halt=1; next start ignored (busy stays 0) until clear_halt.
REQ-026 7410 (SKP) at pc=7776 -> pc=0000; 7000 (NOP) at pc=7777 -> pc=0000.
REQ-027 1234 -> illegal and done pulse 1 cycle after start; ac/l unchanged; pc+1.
REQ-028 MQ_EN: 7421 (MQL), ac=5555 -> mq=5555, ac=0000; then 7501 (MQA) -> ac=5555. rst_n low during CAPTURE -> no done, all outputs 0.
